// File: rtl/issue_dispatch.sv
// rtl/issue_dispatch.sv - dual-issue dispatch with load-use scoreboard and EX-stage registers.
// Optional perf counters are enabled by defining ISSUE_PERF_CNT_EN.
package Public_Info;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [4:0]  rf_rd;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        mem_we;
    logic [2:0]  br_type;
  } PC_set;
endpackage

module issue_dispatch
  import Public_Info::*;
(
  input  logic       clk,
  input  logic       rst,
  input  PC_set      i_PC_set1,
  input  PC_set      i_PC_set2,
  input  logic [1:0] i_is_valid,
  input  logic       flush_BR,
  input  logic       stall_DCache,
  output logic [1:0] o_usingNUM,
  output PC_set      o_PC_set_a,
  output PC_set      o_PC_set_b,
  output logic [1:0] o_ex_valid
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0] o_dual_cnt,
  output logic [31:0] o_single_cnt,
  output logic [31:0] o_bubble_cnt
`endif
);

  logic [4:0] r_ld_rd;
  logic       r_ld_vld;

  logic w_normal;
  logic w_load1, w_load2, w_mem1, w_mem2, w_br2;
  logic w_a_ld_hit, w_b_ld_hit, w_b_raw, w_b_waw;
  logic w_issue_a, w_issue_b;

  // A zero register never creates a dependency, whichever side of the compare it sits on.
  function automatic logic f_match(input logic [4:0] raddr, input logic [4:0] r);
    return (r != 5'd0) && (raddr != 5'd0) && (raddr == r);
  endfunction

  always_comb begin
    w_normal   = !flush_BR && !stall_DCache;
    w_load1    = i_PC_set1.rf_we && (i_PC_set1.wb_sel == 2'd1);
    w_load2    = i_PC_set2.rf_we && (i_PC_set2.wb_sel == 2'd1);
    w_mem1     = w_load1 || i_PC_set1.mem_we;
    w_mem2     = w_load2 || i_PC_set2.mem_we;
    w_br2      = (i_PC_set2.br_type != 3'd0);
    w_a_ld_hit = r_ld_vld && (f_match(i_PC_set1.rf_raddr1, r_ld_rd) ||
                              f_match(i_PC_set1.rf_raddr2, r_ld_rd));
    w_b_ld_hit = r_ld_vld && (f_match(i_PC_set2.rf_raddr1, r_ld_rd) ||
                              f_match(i_PC_set2.rf_raddr2, r_ld_rd));
    w_b_raw    = i_PC_set1.rf_we && (f_match(i_PC_set2.rf_raddr1, i_PC_set1.rf_rd) ||
                                     f_match(i_PC_set2.rf_raddr2, i_PC_set1.rf_rd));
    w_b_waw    = i_PC_set1.rf_we && i_PC_set2.rf_we && (i_PC_set1.rf_rd != 5'd0) &&
                 (i_PC_set1.rf_rd == i_PC_set2.rf_rd);
    w_issue_a  = !rst && w_normal && i_is_valid[1] && !w_a_ld_hit;
    w_issue_b  = w_issue_a && i_is_valid[0] && !w_b_raw && !w_b_ld_hit && !w_b_waw &&
                 !(w_mem1 && w_mem2) && !w_br2;
  end

  always_comb begin
    o_usingNUM = 2'b00;
    if (w_issue_b)      o_usingNUM = 2'b10;
    else if (w_issue_a) o_usingNUM = 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_PC_set_a <= '0;
      o_PC_set_b <= '0;
      o_ex_valid <= 2'b00;
      r_ld_rd    <= 5'd0;
      r_ld_vld   <= 1'b0;
    end else if (flush_BR) begin
      o_ex_valid <= 2'b00;
      r_ld_vld   <= 1'b0;
    end else if (!stall_DCache) begin
      o_PC_set_a <= w_issue_a ? i_PC_set1 : '0;
      o_PC_set_b <= w_issue_b ? i_PC_set2 : '0;
      o_ex_valid <= {w_issue_a, w_issue_b};
      // The youngest issued load is the one the next head can depend on.
      if (w_issue_b && w_load2) begin
        r_ld_rd  <= i_PC_set2.rf_rd;
        r_ld_vld <= 1'b1;
      end else if (w_issue_a && w_load1) begin
        r_ld_rd  <= i_PC_set1.rf_rd;
        r_ld_vld <= 1'b1;
      end else begin
        r_ld_rd  <= 5'd0;
        r_ld_vld <= 1'b0;
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_dual_cnt   <= 32'd0;
      o_single_cnt <= 32'd0;
      o_bubble_cnt <= 32'd0;
    end else if (w_normal && (i_is_valid != 2'b00)) begin
      if (w_issue_b) begin
        if (o_dual_cnt != 32'hFFFF_FFFF) o_dual_cnt <= o_dual_cnt + 32'd1;
      end else if (w_issue_a) begin
        if (o_single_cnt != 32'hFFFF_FFFF) o_single_cnt <= o_single_cnt + 32'd1;
      end else begin
        if (o_bubble_cnt != 32'hFFFF_FFFF) o_bubble_cnt <= o_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_issue_dispatch.sv
// tb/tb_issue_dispatch.sv - directed self-checking bench for issue_dispatch.
// Counter checks are compiled in when ISSUE_PERF_CNT_EN is defined.
module tb_issue_dispatch;
  import Public_Info::*;

  logic       clk = 1'b0;
  logic       rst;
  PC_set      s1, s2;
  logic [1:0] v;
  logic       flush, stall;
  logic [1:0] using_num;
  PC_set      pa, pb;
  logic [1:0] exv;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] dual_cnt, single_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  issue_dispatch dut (
    .clk         (clk),
    .rst         (rst),
    .i_PC_set1   (s1),
    .i_PC_set2   (s2),
    .i_is_valid  (v),
    .flush_BR    (flush),
    .stall_DCache(stall),
    .o_usingNUM  (using_num),
    .o_PC_set_a  (pa),
    .o_PC_set_b  (pb),
    .o_ex_valid  (exv)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .o_dual_cnt  (dual_cnt),
    .o_single_cnt(single_cnt),
    .o_bubble_cnt(bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic PC_set mk(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] r1,
                               input logic [4:0] r2, input logic we, input logic [1:0] wb,
                               input logic mw, input logic [2:0] br);
    PC_set p;
    p.pc = pc; p.rf_rd = rd; p.rf_raddr1 = r1; p.rf_raddr2 = r2;
    p.rf_we = we; p.wb_sel = wb; p.mem_we = mw; p.br_type = br;
    return p;
  endfunction

  function automatic PC_set add_i(input logic [31:0] pc, input logic [4:0] rd,
                                  input logic [4:0] r1, input logic [4:0] r2);
    return mk(pc, rd, r1, r2, 1'b1, 2'd0, 1'b0, 3'd0);
  endfunction

  function automatic PC_set ld_i(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] r1);
    return mk(pc, rd, r1, 5'd0, 1'b1, 2'd1, 1'b0, 3'd0);
  endfunction

  function automatic PC_set st_i(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2);
    return mk(pc, 5'd0, r1, r2, 1'b0, 2'd0, 1'b1, 3'd0);
  endfunction

  function automatic PC_set br_i(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2);
    return mk(pc, 5'd0, r1, r2, 1'b0, 2'd0, 1'b0, 3'd1);
  endfunction

  // Called just after a rising edge: drive, check comb handshake, clock, check EX valid.
  task automatic issue(input string tag, input PC_set a, input PC_set b, input logic [1:0] vv,
                       input logic [1:0] exp_use, input logic [1:0] exp_ex);
    s1 = a; s2 = b; v = vv;
    #1 check({tag, "_use"}, 64'(using_num), 64'(exp_use));
    @(posedge clk);
    #1 check({tag, "_ex"}, 64'(exv), 64'(exp_ex));
  endtask

  PC_set nil, A, B, C, D, LD7, DEP7;

  initial begin
    nil  = '0;
    A    = add_i(32'h100, 5'd1, 5'd2, 5'd3);
    B    = add_i(32'h104, 5'd4, 5'd5, 5'd6);
    C    = add_i(32'h200, 5'd11, 5'd12, 5'd13);
    D    = add_i(32'h204, 5'd14, 5'd15, 5'd16);
    LD7  = ld_i(32'h300, 5'd7, 5'd2);
    DEP7 = add_i(32'h304, 5'd10, 5'd7, 5'd3);

    rst = 1'b1; flush = 1'b0; stall = 1'b0; s1 = A; s2 = B; v = 2'b11;
    #2;
    check("rst_ex", 64'(exv), 64'd0);
    check("rst_use", 64'(using_num), 64'd0);
    check("rst_pca", 64'(pa), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_ex", 64'(exv), 64'd0);
    rst = 1'b0;

    issue("dual", A, B, 2'b11, 2'b10, 2'b11);
    check("dual_pca", 64'(pa), 64'(A));
    check("dual_pcb", 64'(pb), 64'(B));

    issue("raw", B, add_i(32'h108, 5'd8, 5'd4, 5'd1), 2'b11, 2'b01, 2'b10);
    check("raw_pcb", 64'(pb), 64'd0);
    issue("raw_next", add_i(32'h108, 5'd8, 5'd4, 5'd1), add_i(32'h10c, 5'd9, 5'd2, 5'd3),
          2'b11, 2'b10, 2'b11);

    issue("waw", add_i(32'h110, 5'd3, 5'd1, 5'd2), add_i(32'h114, 5'd3, 5'd5, 5'd6),
          2'b11, 2'b01, 2'b10);

    issue("ld", LD7, nil, 2'b10, 2'b01, 2'b10);
    issue("lduse", DEP7, nil, 2'b10, 2'b00, 2'b00);
    issue("ldgo", DEP7, nil, 2'b10, 2'b01, 2'b10);
    check("ldgo_pca", 64'(pa), 64'(DEP7));

    issue("ldb", A, LD7, 2'b11, 2'b10, 2'b11);
    issue("ldb_use", DEP7, nil, 2'b10, 2'b00, 2'b00);

    issue("st2", st_i(32'h400, 5'd2, 5'd3), st_i(32'h404, 5'd4, 5'd5), 2'b11, 2'b01, 2'b10);
    issue("br2", A, br_i(32'h408, 5'd4, 5'd5), 2'b11, 2'b01, 2'b10);
    issue("r0", add_i(32'h40c, 5'd0, 5'd2, 5'd3), add_i(32'h410, 5'd0, 5'd0, 5'd0),
          2'b11, 2'b10, 2'b11);
    issue("none", A, B, 2'b00, 2'b00, 2'b00);

    issue("pre_stall", A, B, 2'b11, 2'b10, 2'b11);
    stall = 1'b1;
    issue("stall1", C, D, 2'b11, 2'b00, 2'b11);
    check("stall1_pca", 64'(pa), 64'(A));
    check("stall1_pcb", 64'(pb), 64'(B));
    flush = 1'b1;
    issue("stall2_flush", C, D, 2'b11, 2'b00, 2'b00);
    flush = 1'b0;
    issue("stall3", C, D, 2'b11, 2'b00, 2'b00);
    stall = 1'b0;

    issue("ld_s", LD7, nil, 2'b10, 2'b01, 2'b10);
    stall = 1'b1;
    issue("ld_s_hold", DEP7, nil, 2'b10, 2'b00, 2'b10);
    stall = 1'b0;
    issue("ld_s_use", DEP7, nil, 2'b10, 2'b00, 2'b00);
    issue("ld_s_go", DEP7, nil, 2'b10, 2'b01, 2'b10);

    issue("ld_f", LD7, nil, 2'b10, 2'b01, 2'b10);
    flush = 1'b1;
    issue("ld_f_fl", DEP7, nil, 2'b10, 2'b00, 2'b00);
    flush = 1'b0;
    issue("ld_f_go", DEP7, nil, 2'b10, 2'b01, 2'b10);

    issue("pre_rst", LD7, nil, 2'b10, 2'b01, 2'b10);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ex", 64'(exv), 64'd0);
    check("mid_rst_use", 64'(using_num), 64'd0);
    check("mid_rst_pca", 64'(pa), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef ISSUE_PERF_CNT_EN
    check("cnt_rst_dual", 64'(dual_cnt), 64'd0);
    check("cnt_rst_single", 64'(single_cnt), 64'd0);
    check("cnt_rst_bubble", 64'(bubble_cnt), 64'd0);
`endif
    issue("post_rst_dep", DEP7, nil, 2'b10, 2'b01, 2'b10);
    for (int i = 0; i < 5; i++) issue("cnt_dual", A, B, 2'b11, 2'b10, 2'b11);
`ifdef ISSUE_PERF_CNT_EN
    check("cnt_dual", 64'(dual_cnt), 64'd5);
    check("cnt_single", 64'(single_cnt), 64'd1);
    check("cnt_bubble", 64'(bubble_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_dispatch.md
ISSUE_DISPATCH -- requirements
Module: issue_dispatch

Interface
REQ-001 SHALL have: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: i_PC_set1  input  PC_set (Public_Info)  issue-buffer head entry (slot A candidate).
REQ-004 SHALL have: i_PC_set2  input  PC_set  issue-buffer head+1 entry (slot B candidate).
REQ-005 SHALL have: i_is_valid  input  2  [1]=set1 valid, [0]=set2 valid; 2'b01 never occurs.
REQ-006 SHALL have: flush_BR  input  1  branch-mispredict flush; stall_DCache  input  1  backend stall.
REQ-007 SHALL have: o_usingNUM  output  2  entries consumed this cycle, combinational: 0, 1 (2'b01) or 2 (2'b10).
REQ-008 SHALL have: o_PC_set_a, o_PC_set_b  output  PC_set  registered EX-stage instructions.
REQ-009 SHALL have: o_ex_valid  output  2  registered, [1]=slot a valid, [0]=slot b valid.

Function
REQ-010 SHALL classify an entry as load when rf_we=1 and wb_sel=1, as memory op when load or mem_we=1, as branch when br_type!=0.
REQ-011 SHALL define a source match against register r only when r!=0 and compared raddr is nonzero.
REQ-012 SHALL keep an internal load scoreboard: ld_rd (5 b) and ld_vld (1 b), loaded on each issuing edge from the youngest issued load (slot b over slot a), cleared otherwise.
REQ-013 SHALL issue slot A iff i_is_valid[1]=1, no stall, no flush, and neither rf_raddr1 nor rf_raddr2 of set1 matches ld_rd while ld_vld=1.
REQ-014 SHALL issue slot B iff slot A issues, i_is_valid[0]=1, and all hold: set2 sources do not match set1.rf_rd when set1.rf_we=1; set2 sources do not match ld_rd under ld_vld; not (set1.rf_we and set2.rf_we and equal nonzero rd); not both memory ops; set2 is not a branch.
REQ-015 SHALL drive o_usingNUM = 2'b10 for dual issue, 2'b01 for A only, 2'b00 otherwise, in the same cycle (zero-latency handshake with the buffer).
REQ-016 SHALL, on a normal edge, load o_PC_set_a/b with issued entries and o_ex_valid with issue flags; a non-issued slot gets valid 0 and an all-zero PC_set.
REQ-017 SHALL, when stall_DCache=1 and flush_BR=0, hold o_PC_set_a/b, o_ex_valid, ld_rd, ld_vld; o_usingNUM=0.
REQ-018 SHALL, when flush_BR=1 (priority over stall), clear o_ex_valid, ld_vld on the edge; o_usingNUM=0 that cycle.
REQ-019 SHALL give one-cycle load-use bubble: dependent instruction issues the cycle after the load's bubble cycle.
REQ-020 SHALL never issue slot B without slot A (in-order).

Reset
REQ-021 SHALL, while rst=1, asynchronously force o_ex_valid=2'b00, o_PC_set_a/b all-zero, ld_vld=0, ld_rd=0, counters 0.
REQ-022 SHALL force o_usingNUM=0 while rst=1; reset deasserting mid-operation resumes issue on the next edge with empty scoreboard.

Configuration
REQ-023 SHALL, when ISSUE_PERF_CNT_EN is defined, add outputs o_dual_cnt, o_single_cnt, o_bubble_cnt (32 b each), incremented per non-stalled, non-flushed edge with 2, 1, or 0 issued while i_is_valid!=0; saturating at 32'hFFFF_FFFF.
REQ-024 SHALL, without ISSUE_PERF_CNT_EN, omit these ports and counters; all other behaviour identical.

Verification
REQ-025 Independent ADDs (r1<-r2,r3; r4<-r5,r6), i_is_valid=2'b11 -> o_usingNUM=2'b10, next edge o_ex_valid=2'b11.
REQ-026 set1 writes r4, set2 reads r4 -> o_usingNUM=2'b01, o_ex_valid=2'b10; next cycle old set2 issues as slot a.
REQ-027 LD r7 issued, next head reads r7 -> one cycle o_usingNUM=0, o_ex_valid=2'b00, then issue, o_ex_valid[1]=1.
REQ-028 Two stores at head -> usingNUM=2'b01; branch in set2 -> usingNUM=2'b01; reads of r0 never block.
REQ-029 stall_DCache=1 for 3 cycles with flush_BR=1 in cycle 2 -> usingNUM=0 throughout, EX regs held cycle 1, o_ex_valid=0 after flush edge.
REQ-030 rst pulsed high mid-stream -> o_ex_valid=0 immediately (no clock); with ISSUE_PERF_CNT_EN, counters read 0 and count 5 dual issues as o_dual_cnt=5.
